// File: rtl/ascii_to_ps2_tx_if.sv
// Character handshake between the cipher datapath and the PS/2 keystroke
// transmitter. The producer (master) offers one ASCII code per transfer and
// the transmitter (slave) signals when it can take the next one.
interface ascii_to_ps2_tx_if;
    logic       ascii_valid;
    logic [7:0] ascii_char;
    logic       ascii_ready;

    modport master (
        output ascii_valid,
        output ascii_char,
        input  ascii_ready
    );

    modport slave (
        input  ascii_valid,
        input  ascii_char,
        output ascii_ready
    );
endinterface

// File: rtl/ascii_to_ps2_tx.sv
// ASCII letter to PS/2 set-2 keystroke transmitter.
// Each accepted letter is sent as three device-to-host frames
// (make, F0, make) separated by idle gaps with both lines high.
// Characters that are not letters are dropped and flagged by a one-cycle
// bad_char pulse without disturbing the PS/2 lines.
module ascii_to_ps2_tx #(
    parameter int HALF_BIT_CLKS = 2500,
    parameter int GAP_CLKS      = 5000
) (
    input  logic              clock,
    input  logic              reset,
    ascii_to_ps2_tx_if.slave  ascii,
    output logic              ps2_clk_out,
    output logic              ps2_data_out,
    output logic              busy,
    output logic              bad_char
);

    localparam int HALF_W = (HALF_BIT_CLKS > 2) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_BIT_CLKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Letter to make code; bit 8 set means the character is supported.
    function automatic logic [8:0] map_ascii(input logic [7:0] c);
        logic [7:0] upper;
        logic [8:0] res;
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            upper = c - 8'h20;
        end else begin
            upper = c;
        end
        case (upper)
            8'h41:   res = {1'b1, 8'h1C};
            8'h42:   res = {1'b1, 8'h32};
            8'h43:   res = {1'b1, 8'h21};
            8'h44:   res = {1'b1, 8'h23};
            8'h45:   res = {1'b1, 8'h24};
            8'h46:   res = {1'b1, 8'h2B};
            8'h47:   res = {1'b1, 8'h34};
            8'h48:   res = {1'b1, 8'h33};
            8'h49:   res = {1'b1, 8'h43};
            8'h4A:   res = {1'b1, 8'h3B};
            8'h4B:   res = {1'b1, 8'h42};
            8'h4C:   res = {1'b1, 8'h4B};
            8'h4D:   res = {1'b1, 8'h3A};
            8'h4E:   res = {1'b1, 8'h31};
            8'h4F:   res = {1'b1, 8'h44};
            8'h50:   res = {1'b1, 8'h4D};
            8'h51:   res = {1'b1, 8'h15};
            8'h52:   res = {1'b1, 8'h2D};
            8'h53:   res = {1'b1, 8'h1B};
            8'h54:   res = {1'b1, 8'h2C};
            8'h55:   res = {1'b1, 8'h3C};
            8'h56:   res = {1'b1, 8'h2A};
            8'h57:   res = {1'b1, 8'h1D};
            8'h58:   res = {1'b1, 8'h22};
            8'h59:   res = {1'b1, 8'h35};
            8'h5A:   res = {1'b1, 8'h1A};
            default: res = {1'b0, 8'h00};
        endcase
        return res;
    endfunction

    // Odd parity over the data byte: the 9 bits together hold an odd count of 1s.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Full 11-bit frame, bit 0 transmitted first: start, data LSB first, parity, stop.
    function automatic logic [10:0] frame_word(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

    // Byte carried by frame index 0/1/2 of a keystroke.
    function automatic logic [7:0] byte_for(input logic [1:0] idx, input logic [7:0] make);
        logic [7:0] res;
        case (idx)
            2'd1:    res = 8'hF0;
            default: res = make;
        endcase
        return res;
    endfunction

    state_t              state_r;
    logic [7:0]          make_code_r;
    logic [1:0]          byte_idx_r;
    logic [3:0]          bit_cnt_r;
    logic [HALF_W-1:0]   half_cnt_r;
    logic                phase_low_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic                ps2_clk_r;
    logic                ps2_data_r;
    logic                busy_r;
    logic                ready_r;
    logic                bad_char_r;

    logic [8:0]          map_s;
    logic                xfer_s;
    logic [10:0]         word_s;
    logic [3:0]          next_bit_s;

    assign map_s      = map_ascii(ascii.ascii_char);
    assign xfer_s     = ascii.ascii_valid && ready_r;
    assign word_s     = frame_word(byte_for(byte_idx_r, make_code_r));
    assign next_bit_s = bit_cnt_r + 4'd1;

    assign ascii.ascii_ready = ready_r;
    assign ps2_clk_out       = ps2_clk_r;
    assign ps2_data_out      = ps2_data_r;
    assign busy              = busy_r;
    assign bad_char          = bad_char_r;

    // Keystroke sequencer: accepts a letter, then walks frame/gap/frame/gap/frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            make_code_r <= 8'h00;
            byte_idx_r  <= 2'd0;
            bit_cnt_r   <= 4'd0;
            half_cnt_r  <= '0;
            phase_low_r <= 1'b0;
            gap_cnt_r   <= '0;
            ps2_clk_r   <= 1'b1;
            ps2_data_r  <= 1'b1;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            bad_char_r  <= 1'b0;
        end else begin
            bad_char_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_r  <= 1'b1;
                    ps2_data_r <= 1'b1;
                    if (xfer_s) begin
                        if (map_s[8]) begin
                            // First cycle of the start bit's high phase.
                            state_r     <= ST_FRAME;
                            make_code_r <= map_s[7:0];
                            byte_idx_r  <= 2'd0;
                            bit_cnt_r   <= 4'd0;
                            half_cnt_r  <= '0;
                            phase_low_r <= 1'b0;
                            ps2_data_r  <= 1'b0;
                            busy_r      <= 1'b1;
                            ready_r     <= 1'b0;
                        end else begin
                            bad_char_r <= 1'b1;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end

                ST_FRAME: begin
                    if (half_cnt_r == HALF_LAST) begin
                        half_cnt_r <= '0;
                        if (!phase_low_r) begin
                            phase_low_r <= 1'b1;
                            ps2_clk_r   <= 1'b0;
                        end else if (bit_cnt_r == 4'd10) begin
                            // Stop bit done: lines back high.
                            phase_low_r <= 1'b0;
                            ps2_clk_r   <= 1'b1;
                            ps2_data_r  <= 1'b1;
                            if (byte_idx_r == 2'd2) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                                ready_r <= 1'b1;
                            end else begin
                                state_r    <= ST_GAP;
                                gap_cnt_r  <= '0;
                                byte_idx_r <= byte_idx_r + 2'd1;
                            end
                        end else begin
                            // Data changes only at the start of a high phase.
                            bit_cnt_r   <= next_bit_s;
                            phase_low_r <= 1'b0;
                            ps2_clk_r   <= 1'b1;
                            ps2_data_r  <= word_s[next_bit_s];
                        end
                    end else begin
                        half_cnt_r <= half_cnt_r + {{(HALF_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r     <= ST_FRAME;
                        bit_cnt_r   <= 4'd0;
                        half_cnt_r  <= '0;
                        phase_low_r <= 1'b0;
                        ps2_clk_r   <= 1'b1;
                        ps2_data_r  <= 1'b0;
                    end else begin
                        gap_cnt_r  <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                        ps2_clk_r  <= 1'b1;
                        ps2_data_r <= 1'b1;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    ps2_clk_r  <= 1'b1;
                    ps2_data_r <= 1'b1;
                    busy_r     <= 1'b0;
                    ready_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule
